layer_tile_sequencer: RTL and testbench
=======================================

# layer_tile_sequencer

Per-layer tile sequencer sitting directly downstream of `main_controller`. On each `start_layer` pulse it latches the current layer configuration and derives the output geometry. It then walks the layer as a sequence of systolic-array tiles (filter groups × input-channel groups), issuing a start per tile and waiting for completion. After the last tile it returns the one-cycle `done_layer` pulse that advances `main_controller` to the next layer.

## Interface
Parameters:
- `SYSTOLIC_SIZE`, 16: PE array dimension. Must be a power of two.
- `OFM_RAM_SIZE`, 2378675: OFM RAM depth. `ADDR_W = $clog2(OFM_RAM_SIZE)`.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start_layer` in 1: one-cycle start pulse; config inputs are valid in that cycle.
- `ifm_size` in 9, `ifm_channel` in 11, `kernel_size` in 2, `num_filter` in 11: layer config.
- `maxpool_mode` in 1, `maxpool_stride` in 2, `upsample_mode` in 1: layer config.
- `start_write_addr` in ADDR_W, `start_read_addr` in ADDR_W: layer config.
- `tile_done` in 1: pulse from the PE datapath marking the current tile finished.
- `tile_start` out 1: one-cycle pulse; tile address outputs are valid in that cycle.
- `tile_read_addr` out ADDR_W: IFM base address of the current tile.
- `tile_write_addr` out ADDR_W: OFM base address of the current tile.
- `tile_first_ch` out 1: first channel group of the current filter group (clear accumulator).
- `tile_last_ch` out 1: last channel group (apply activation/pool, write OFM).
- `out_size` out 9: latched output spatial size.
- `busy` out 1: high from the cycle after `start_layer` until `done_layer`, inclusive.
- `done_layer` out 1: one-cycle pulse at layer end.

## Operation
- **States:** IDLE, SETUP, ISSUE, WAIT, NEXT, DONE.
- **IDLE:**
  - On `start_layer`, latch all config inputs and go to SETUP.
  - `start_layer` is ignored in every other state.
- **SETUP:** compute the following, then go to ISSUE (or to DONE if either group count is 0).
  - `conv = ifm_size - kernel_size + 1`.
  - `pool`: if `maxpool_mode` is 0, `pool = conv`; stride 2 gives `conv>>1`; stride 1 gives `conv-1`.
  - `out_size`: `pool<<1` if `upsample_mode`, else `pool`.
  - `wstride = SYSTOLIC_SIZE*out_size²`.
  - `rstride = SYSTOLIC_SIZE*ifm_size²`.
  - `nf_grp = ceil(num_filter/SYSTOLIC_SIZE)` and `nc_grp = ceil(ifm_channel/SYSTOLIC_SIZE)`, each computed as add-then-shift.
  - Reset counters `f = 0`, `c = 0`; set read pointer to `start_read_addr` and write pointer to `start_write_addr`.
- **ISSUE:** assert `tile_start` for one cycle, then go to WAIT.
- **WAIT:** hold until `tile_done`, then go to NEXT. `tile_done` is ignored outside WAIT.
- **NEXT:** channel group is the inner loop, filter group the outer loop.
  - If `c < nc_grp-1`: `c++`, read pointer `+= rstride`, go to ISSUE.
  - Else if `f < nf_grp-1`: `f++`, `c = 0`, read pointer `= start_read_addr`, write pointer `+= wstride`, go to ISSUE.
  - Else go to DONE.
- **DONE:** `done_layer = 1` for one cycle, then IDLE.
- **Arithmetic:**
  - Addresses wrap modulo 2^ADDR_W; no overflow flag.
  - No multipliers in the tile loop. The squares in SETUP may use a multiplier or a small multi-cycle shift-add; if multi-cycle, SETUP stretches and all latencies below shift by the same amount.
- **Flags:** `tile_first_ch = (c==0)`, `tile_last_ch = (c==nc_grp-1)`. Both are valid whenever `tile_start` is high.

## Timing
- **Reset values:** all outputs 0; state IDLE.
- **Mid-operation reset:** reset wins over every other input; the block returns to IDLE and emits no `done_layer`.
- **Start latency:** `start_layer` at cycle T gives `busy` high at T+1 and the first `tile_start` at T+2.
- **Tile turnaround:** `tile_done` at cycle W gives NEXT at W+1, then either the next `tile_start` or `done_layer` at W+2.
- **Simultaneous inputs:** `tile_done` in the same cycle as `tile_start` is ignored.
- **Empty layer:** `num_filter==0` or `ifm_channel==0` gives `done_layer` at T+2 and no `tile_start`.
- **Upstream contract:** `done_layer` is registered and exactly one cycle wide. `main_controller` advances its layer count on the pulse's falling edge and re-issues `start_layer` one cycle later.
- **Output stability:** address and flag outputs stay stable from ISSUE through WAIT.

## Structure
- **Shared package `cnn_pkg`:**
  - state enum;
  - `SYSTOLIC_LOG2` constant;
  - `ceil_div_pow2` function.
- **Sub-module `layer_geom`:** registered computation of `out_size`, `wstride`, `rstride`, `nf_grp` and `nc_grp` from the latched config. It is used in SETUP.

## Test plan
- **Layer 1 config** (ifm 54, ch 3, k 3, nf 16, pool s2, write 0, read 0) gives:
  - `out_size` = 26;
  - exactly 1 `tile_start` at T+2 with read 0, write 0, first=1, last=1;
  - `done_layer` at W+2;
  - `wstride` = 10816.
- **Multi-tile layer** (ifm 12, ch 32, k 3, nf 32, pool s2, write 13120, read 10816) gives 4 tiles in order (f0,c0), (f0,c1), (f1,c0), (f1,c1):
  - read addresses 10816, 13120, 10816, 13120;
  - write addresses 13120, 13120, 13520, 13520;
  - `tile_last_ch` on tiles 2 and 4 only.
- **Rounding** (nf 255, ch 3, ifm 13, k 1, no pool) gives `out_size` = 13 and 16 tiles, each with first=last=1.
- **Ignored inputs:** `start_layer` and stray `tile_done` pulses injected during WAIT/ISSUE produce no extra tiles and no early `done_layer`.
- **Empty layer:** `num_filter` = 0 gives no `tile_start` and `done_layer` at T+2.
- **Reset mid-operation:** `rst_n` low during tile 2 of the multi-tile layer clears all outputs on the next edge with no `done_layer`. A following `start_layer` restarts cleanly from tile (f0,c0).

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the layer tile sequencer.
// State encoding, systolic array constants and group-count rounding.
package cnn_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    localparam int SYSTOLIC_LOG2 = 4;

    // Width of filter/channel group counts (11-bit config plus rounding)
    localparam int GRP_W = 12;

    // ceil(val / 2^lg) done as add-then-shift
    function automatic logic [GRP_W-1:0] ceil_div_pow2(
        input logic [GRP_W-1:0] val,
        input int unsigned      lg
    );
        logic [GRP_W-1:0] bias;
        bias = GRP_W'((1 << lg) - 1);
        return (val + bias) >> lg;
    endfunction

endpackage

// File: rtl/layer_tile_sequencer_if.sv
// Tile command bus between the sequencer and the PE datapath.
// The sequencer drives tile starts; the datapath answers with tile_done.
interface layer_tile_sequencer_if #(
    parameter int ADDR_W = 22
);
    logic              tile_start;
    logic [ADDR_W-1:0] tile_read_addr;
    logic [ADDR_W-1:0] tile_write_addr;
    logic              tile_first_ch;
    logic              tile_last_ch;
    logic              tile_done;

    modport master (
        output tile_start,
        output tile_read_addr,
        output tile_write_addr,
        output tile_first_ch,
        output tile_last_ch,
        input  tile_done
    );

    modport slave (
        input  tile_start,
        input  tile_read_addr,
        input  tile_write_addr,
        input  tile_first_ch,
        input  tile_last_ch,
        output tile_done
    );
endinterface

// File: rtl/layer_geom.sv
// Layer geometry: output size, per-group address strides, group counts.
// Combinational from the latched config, captured on load.
module layer_geom
    import cnn_pkg::*;
#(
    parameter int LOG2   = SYSTOLIC_LOG2,
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [8:0]        ifm_size,
    input  logic [10:0]       ifm_channel,
    input  logic [1:0]        kernel_size,
    input  logic [10:0]       num_filter,
    input  logic              maxpool_mode,
    input  logic [1:0]        maxpool_stride,
    input  logic              upsample_mode,
    output logic              empty,
    output logic              single_ch,
    output logic [8:0]        out_size,
    output logic [ADDR_W-1:0] wstride,
    output logic [ADDR_W-1:0] rstride,
    output logic [GRP_W-1:0]  nf_grp,
    output logic [GRP_W-1:0]  nc_grp
);

    logic [8:0]        conv;
    logic [8:0]        pool;
    logic [8:0]        out_d;
    logic [17:0]       osq;
    logic [17:0]       isq;
    logic [ADDR_W-1:0] wstride_d;
    logic [ADDR_W-1:0] rstride_d;
    logic [GRP_W-1:0]  nf_d;
    logic [GRP_W-1:0]  nc_d;

    assign conv = ifm_size - {7'd0, kernel_size} + 9'd1;

    // Pooling shrink then optional 2x upsample
    always_comb begin
        pool = conv;
        if (maxpool_mode) begin
            pool = (maxpool_stride == 2'd1) ? conv - 9'd1 : conv >> 1;
        end
        out_d = upsample_mode ? pool << 1 : pool;
    end

    assign osq       = {9'd0, out_d} * {9'd0, out_d};
    assign isq       = {9'd0, ifm_size} * {9'd0, ifm_size};
    assign wstride_d = ADDR_W'({osq, {LOG2{1'b0}}});
    assign rstride_d = ADDR_W'({isq, {LOG2{1'b0}}});
    assign nf_d      = ceil_div_pow2({1'b0, num_filter}, LOG2);
    assign nc_d      = ceil_div_pow2({1'b0, ifm_channel}, LOG2);
    assign empty     = (nf_d == '0) || (nc_d == '0);
    assign single_ch = (nc_d == GRP_W'(1));

    // Hold geometry for the whole tile walk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_size <= '0;
            wstride  <= '0;
            rstride  <= '0;
            nf_grp   <= '0;
            nc_grp   <= '0;
        end else if (load) begin
            out_size <= out_d;
            wstride  <= wstride_d;
            rstride  <= rstride_d;
            nf_grp   <= nf_d;
            nc_grp   <= nc_d;
        end
    end

endmodule

// File: rtl/layer_tile_sequencer.sv
// Per-layer tile sequencer: walks filter groups x channel groups,
// issuing one tile at a time and reporting layer completion.
module layer_tile_sequencer
    import cnn_pkg::*;
#(
    parameter int  SYSTOLIC_SIZE = 16,
    parameter int  OFM_RAM_SIZE  = 2378675,
    localparam int ADDR_W        = $clog2(OFM_RAM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_layer,
    input  logic [8:0]             ifm_size,
    input  logic [10:0]            ifm_channel,
    input  logic [1:0]             kernel_size,
    input  logic [10:0]            num_filter,
    input  logic                   maxpool_mode,
    input  logic [1:0]             maxpool_stride,
    input  logic                   upsample_mode,
    input  logic [ADDR_W-1:0]      start_write_addr,
    input  logic [ADDR_W-1:0]      start_read_addr,
    layer_tile_sequencer_if.master tile,
    output logic [8:0]             out_size,
    output logic                   busy,
    output logic                   done_layer
);

    localparam int SYS_LOG2 = $clog2(SYSTOLIC_SIZE);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_SETUP = ST_SETUP;
    localparam logic [2:0] S_ISSUE = ST_ISSUE;
    localparam logic [2:0] S_WAIT  = ST_WAIT;
    localparam logic [2:0] S_NEXT  = ST_NEXT;
    localparam logic [2:0] S_DONE  = ST_DONE;

    localparam logic [GRP_W-1:0] G_ONE = GRP_W'(1);

    logic [2:0]        state;

    logic [8:0]        cfg_ifm_size;
    logic [10:0]       cfg_ifm_channel;
    logic [1:0]        cfg_kernel_size;
    logic [10:0]       cfg_num_filter;
    logic              cfg_maxpool_mode;
    logic [1:0]        cfg_maxpool_stride;
    logic              cfg_upsample_mode;
    logic [ADDR_W-1:0] cfg_wr_base;
    logic [ADDR_W-1:0] cfg_rd_base;

    logic              geom_empty;
    logic              geom_single_ch;
    logic [ADDR_W-1:0] wstride;
    logic [ADDR_W-1:0] rstride;
    logic [GRP_W-1:0]  nf_grp;
    logic [GRP_W-1:0]  nc_grp;

    logic [GRP_W-1:0]  f_cnt;
    logic [GRP_W-1:0]  c_cnt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic              start_q;
    logic              first_q;
    logic              last_q;

    logic              c_more;
    logic              f_more;
    logic              c_next_last;

    assign c_more      = c_cnt < (nc_grp - G_ONE);
    assign f_more      = f_cnt < (nf_grp - G_ONE);
    assign c_next_last = (c_cnt + G_ONE) == (nc_grp - G_ONE);

    assign tile.tile_start      = start_q;
    assign tile.tile_read_addr  = rd_ptr;
    assign tile.tile_write_addr = wr_ptr;
    assign tile.tile_first_ch   = first_q;
    assign tile.tile_last_ch    = last_q;

    layer_geom #(
        .LOG2   (SYS_LOG2),
        .ADDR_W (ADDR_W)
    ) u_geom (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (state == S_SETUP),
        .ifm_size       (cfg_ifm_size),
        .ifm_channel    (cfg_ifm_channel),
        .kernel_size    (cfg_kernel_size),
        .num_filter     (cfg_num_filter),
        .maxpool_mode   (cfg_maxpool_mode),
        .maxpool_stride (cfg_maxpool_stride),
        .upsample_mode  (cfg_upsample_mode),
        .empty          (geom_empty),
        .single_ch      (geom_single_ch),
        .out_size       (out_size),
        .wstride        (wstride),
        .rstride        (rstride),
        .nf_grp         (nf_grp),
        .nc_grp         (nc_grp)
    );

    // Capture layer config only when a start is accepted in IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ifm_size       <= '0;
            cfg_ifm_channel    <= '0;
            cfg_kernel_size    <= '0;
            cfg_num_filter     <= '0;
            cfg_maxpool_mode   <= 1'b0;
            cfg_maxpool_stride <= '0;
            cfg_upsample_mode  <= 1'b0;
            cfg_wr_base        <= '0;
            cfg_rd_base        <= '0;
        end else if (state == S_IDLE && start_layer) begin
            cfg_ifm_size       <= ifm_size;
            cfg_ifm_channel    <= ifm_channel;
            cfg_kernel_size    <= kernel_size;
            cfg_num_filter     <= num_filter;
            cfg_maxpool_mode   <= maxpool_mode;
            cfg_maxpool_stride <= maxpool_stride;
            cfg_upsample_mode  <= upsample_mode;
            cfg_wr_base        <= start_write_addr;
            cfg_rd_base        <= start_read_addr;
        end
    end

    // Tile walk: channel groups inner, filter groups outer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done_layer <= 1'b0;
            start_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            f_cnt      <= '0;
            c_cnt      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            start_q    <= 1'b0;
            done_layer <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_layer) begin
                        busy  <= 1'b1;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    f_cnt  <= '0;
                    c_cnt  <= '0;
                    rd_ptr <= cfg_rd_base;
                    wr_ptr <= cfg_wr_base;
                    if (geom_empty) begin
                        done_layer <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        start_q <= 1'b1;
                        first_q <= 1'b1;
                        last_q  <= geom_single_ch;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tile.tile_done) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (c_more) begin
                        c_cnt   <= c_cnt + G_ONE;
                        rd_ptr  <= rd_ptr + rstride;
                        first_q <= 1'b0;
                        last_q  <= c_next_last;
                        start_q <= 1'b1;
                        state   <= S_ISSUE;
                    end else if (f_more) begin
                        f_cnt   <= f_cnt + G_ONE;
                        c_cnt   <= '0;
                        rd_ptr  <= cfg_rd_base;
                        wr_ptr  <= wr_ptr + wstride;
                        first_q <= 1'b1;
                        last_q  <= (nc_grp == G_ONE);
                        start_q <= 1'b1;
                        state   <= S_ISSUE;
                    end else begin
                        done_layer <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_tile_sequencer.sv
// Directed bench for layer_tile_sequencer.
// The bench plays the PE datapath and checks tiles against hand values.
module tb_layer_tile_sequencer;

    localparam int ADDR_W = $clog2(2378675);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_layer;
    logic [8:0]        ifm_size;
    logic [10:0]       ifm_channel;
    logic [1:0]        kernel_size;
    logic [10:0]       num_filter;
    logic              maxpool_mode;
    logic [1:0]        maxpool_stride;
    logic              upsample_mode;
    logic [ADDR_W-1:0] start_write_addr;
    logic [ADDR_W-1:0] start_read_addr;
    logic [8:0]        out_size;
    logic              busy;
    logic              done_layer;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int                n_tiles;
    int                done_cyc;
    int                last_w;
    logic              busy_at1;
    logic              busy_at_done;
    logic [ADDR_W-1:0] cap_rd [32];
    logic [ADDR_W-1:0] cap_wr [32];
    logic              cap_first [32];
    logic              cap_last [32];
    int                cap_cyc [32];

    always #5 clk = ~clk;

    layer_tile_sequencer_if #(.ADDR_W(ADDR_W)) tile_bus ();

    layer_tile_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_layer      (start_layer),
        .ifm_size         (ifm_size),
        .ifm_channel      (ifm_channel),
        .kernel_size      (kernel_size),
        .num_filter       (num_filter),
        .maxpool_mode     (maxpool_mode),
        .maxpool_stride   (maxpool_stride),
        .upsample_mode    (upsample_mode),
        .start_write_addr (start_write_addr),
        .start_read_addr  (start_read_addr),
        .tile             (tile_bus),
        .out_size         (out_size),
        .busy             (busy),
        .done_layer       (done_layer)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int isz, input int ch, input int k,
                           input int nf, input bit mp, input int st,
                           input bit up, input int wa, input int ra);
        ifm_size         = 9'(isz);
        ifm_channel      = 11'(ch);
        kernel_size      = 2'(k);
        num_filter       = 11'(nf);
        maxpool_mode     = mp;
        maxpool_stride   = 2'(st);
        upsample_mode    = up;
        start_write_addr = ADDR_W'(wa);
        start_read_addr  = ADDR_W'(ra);
    endtask

    // Start a layer at cycle 0 and act as the datapath until done_layer
    task automatic run_layer(input int delay, input bit inject);
        int pend;
        pend         = -1;
        n_tiles      = 0;
        done_cyc     = -1;
        last_w       = -1;
        busy_at1     = 1'b0;
        busy_at_done = 1'b0;
        tick();
        start_layer = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            start_layer       = 1'b0;
            tile_bus.tile_done = 1'b0;
            if (k == 1) busy_at1 = busy;
            if (done_layer) begin
                done_cyc     = k;
                busy_at_done = busy;
                break;
            end
            if (tile_bus.tile_start) begin
                if (n_tiles < 32) begin
                    cap_rd[n_tiles]    = tile_bus.tile_read_addr;
                    cap_wr[n_tiles]    = tile_bus.tile_write_addr;
                    cap_first[n_tiles] = tile_bus.tile_first_ch;
                    cap_last[n_tiles]  = tile_bus.tile_last_ch;
                    cap_cyc[n_tiles]   = k;
                end
                n_tiles++;
                pend = k + delay;
                if (inject) begin
                    tile_bus.tile_done = 1'b1;
                    start_layer        = 1'b1;
                end
            end else if (k == pend) begin
                tile_bus.tile_done = 1'b1;
                last_w             = k;
            end else if (inject && k == pend - delay + 1) begin
                start_layer = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        start_layer        = 1'b0;
        tile_bus.tile_done = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk_cnt++;
        if ({tile_bus.tile_start, busy, done_layer} !== 3'b000)
            $display("FAIL reset_ctrl: got %b want 000",
                     {tile_bus.tile_start, busy, done_layer});
        else pass_cnt++;
        chk_cnt++;
        if ({tile_bus.tile_first_ch, tile_bus.tile_last_ch} !== 2'b00)
            $display("FAIL reset_flags: got %b want 00",
                     {tile_bus.tile_first_ch, tile_bus.tile_last_ch});
        else pass_cnt++;
        chk_cnt++;
        if (tile_bus.tile_read_addr !== '0 || tile_bus.tile_write_addr !== '0
            || out_size !== 9'd0)
            $display("FAIL reset_data: rd %0d wr %0d out %0d want 0",
                     tile_bus.tile_read_addr, tile_bus.tile_write_addr, out_size);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_layer1();
        set_cfg(54, 3, 3, 16, 1, 2, 0, 0, 0);
        run_layer(2, 0);
        chk_cnt++;
        if (n_tiles !== 1) $display("FAIL l1_tiles: got %0d want 1", n_tiles);
        else pass_cnt++;
        chk_cnt++;
        if (cap_cyc[0] !== 2) $display("FAIL l1_start_lat: got %0d want 2", cap_cyc[0]);
        else pass_cnt++;
        chk_cnt++;
        if (cap_rd[0] !== '0 || cap_wr[0] !== '0 || cap_first[0] !== 1'b1
            || cap_last[0] !== 1'b1)
            $display("FAIL l1_tile: rd %0d wr %0d f %b l %b want 0 0 1 1",
                     cap_rd[0], cap_wr[0], cap_first[0], cap_last[0]);
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc !== 6) $display("FAIL l1_done: got %0d want 6", done_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (out_size !== 9'd26) $display("FAIL l1_out_size: got %0d want 26", out_size);
        else pass_cnt++;
        chk_cnt++;
        if (busy_at1 !== 1'b1 || busy_at_done !== 1'b1)
            $display("FAIL l1_busy: got %b%b want 11", busy_at1, busy_at_done);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({busy, done_layer} !== 2'b00)
            $display("FAIL l1_after_done: got %b want 00", {busy, done_layer});
        else pass_cnt++;
    endtask

    task automatic test_wstride();
        set_cfg(54, 3, 3, 32, 1, 2, 0, 100, 0);
        run_layer(2, 0);
        chk_cnt++;
        if (n_tiles !== 2 || cap_wr[1] !== ADDR_W'(10916) || cap_rd[1] !== '0)
            $display("FAIL wstride: n %0d wr %0d rd %0d want 2 10916 0",
                     n_tiles, cap_wr[1], cap_rd[1]);
        else pass_cnt++;
    endtask

    task automatic test_multi(input bit inject, input int delay);
        int exp_rd [4] = '{10816, 13120, 10816, 13120};
        int exp_wr [4] = '{13120, 13120, 13520, 13520};
        bit exp_f  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bit exp_l  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        set_cfg(12, 32, 3, 32, 1, 2, 0, 13120, 10816);
        run_layer(delay, inject);
        chk_cnt++;
        if (n_tiles !== 4) $display("FAIL multi_tiles(inj=%0d): got %0d want 4", inject, n_tiles);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (cap_rd[i] !== ADDR_W'(exp_rd[i]) || cap_wr[i] !== ADDR_W'(exp_wr[i])
                || cap_first[i] !== exp_f[i] || cap_last[i] !== exp_l[i])
                $display("FAIL multi_tile%0d(inj=%0d): rd %0d wr %0d f %b l %b want %0d %0d %b %b",
                         i, inject, cap_rd[i], cap_wr[i], cap_first[i], cap_last[i],
                         exp_rd[i], exp_wr[i], exp_f[i], exp_l[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (cap_cyc[1] !== 2 + delay + 2)
            $display("FAIL multi_turnaround: got %0d want %0d", cap_cyc[1], 2 + delay + 2);
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc !== 4 * (delay + 2) + 2 || done_cyc !== last_w + 2)
            $display("FAIL multi_done(inj=%0d): got %0d want %0d",
                     inject, done_cyc, 4 * (delay + 2) + 2);
        else pass_cnt++;
        chk_cnt++;
        if (out_size !== 9'd5) $display("FAIL multi_out_size: got %0d want 5", out_size);
        else pass_cnt++;
    endtask

    task automatic test_rounding();
        int bad;
        bad = 0;
        set_cfg(13, 3, 1, 255, 0, 0, 0, 0, 5);
        run_layer(1, 0);
        chk_cnt++;
        if (n_tiles !== 16) $display("FAIL round_tiles: got %0d want 16", n_tiles);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            if (cap_first[i] !== 1'b1 || cap_last[i] !== 1'b1 || cap_rd[i] !== ADDR_W'(5)
                || cap_wr[i] !== ADDR_W'(i * 2704))
                bad++;
        end
        chk_cnt++;
        if (bad !== 0) $display("FAIL round_flags_addr: got %0d bad tiles want 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (out_size !== 9'd13) $display("FAIL round_out_size: got %0d want 13", out_size);
        else pass_cnt++;
    endtask

    task automatic test_upsample();
        set_cfg(13, 16, 1, 16, 1, 1, 1, 0, 0);
        run_layer(2, 0);
        chk_cnt++;
        if (out_size !== 9'd24 || n_tiles !== 1)
            $display("FAIL upsample: out %0d n %0d want 24 1", out_size, n_tiles);
        else pass_cnt++;
    endtask

    task automatic test_empty();
        set_cfg(54, 3, 3, 0, 1, 2, 0, 0, 0);
        run_layer(2, 0);
        chk_cnt++;
        if (n_tiles !== 0 || done_cyc !== 2)
            $display("FAIL empty_nf: n %0d done %0d want 0 2", n_tiles, done_cyc);
        else pass_cnt++;
        set_cfg(54, 0, 3, 16, 1, 2, 0, 0, 0);
        run_layer(2, 0);
        chk_cnt++;
        if (n_tiles !== 0 || done_cyc !== 2)
            $display("FAIL empty_ch: n %0d done %0d want 0 2", n_tiles, done_cyc);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int cnt;
        int pend;
        bit seen;
        cnt  = 0;
        pend = -1;
        seen = 0;
        set_cfg(12, 32, 3, 32, 1, 2, 0, 13120, 10816);
        tick();
        start_layer = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            start_layer        = 1'b0;
            tile_bus.tile_done = 1'b0;
            if (tile_bus.tile_start) begin
                cnt++;
                pend = k + 2;
                if (cnt == 2) break;
            end else if (k == pend) begin
                tile_bus.tile_done = 1'b1;
            end
        end
        chk_cnt++;
        if (cnt !== 2) $display("FAIL rmid_reach_tile2: got %0d want 2", cnt);
        else pass_cnt++;
        tick();
        rst_n = 1'b0;
        tick();
        chk_cnt++;
        if ({tile_bus.tile_start, busy, done_layer, tile_bus.tile_first_ch,
             tile_bus.tile_last_ch} !== 5'b00000)
            $display("FAIL rmid_ctrl: got %b want 00000",
                     {tile_bus.tile_start, busy, done_layer, tile_bus.tile_first_ch,
                      tile_bus.tile_last_ch});
        else pass_cnt++;
        chk_cnt++;
        if (tile_bus.tile_read_addr !== '0 || tile_bus.tile_write_addr !== '0
            || out_size !== 9'd0)
            $display("FAIL rmid_data: rd %0d wr %0d out %0d want 0",
                     tile_bus.tile_read_addr, tile_bus.tile_write_addr, out_size);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done_layer || tile_bus.tile_start || busy) seen = 1;
        end
        chk_cnt++;
        if (seen !== 1'b0) $display("FAIL rmid_quiet: got activity %b want 0", seen);
        else pass_cnt++;
        test_multi(0, 2);
    endtask

    initial begin
        test_reset();
        test_layer1();
        test_wstride();
        test_multi(0, 4);
        test_multi(1, 3);
        test_rounding();
        test_upsample();
        test_empty();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
